// File: rtl/codec_vol_scheduler.sv
// codec_vol_scheduler: runtime headphone volume/mute control for the audio codec.
// Keeps a saturating volume register and a mute flag, and pushes every change
// out as a left (reg 0x04) then right (reg 0x06) write through the shared I2C
// controller GO/END/ACK handshake, retrying NACKed words a bounded number of times.
module codec_vol_scheduler #(
   parameter logic [7:0] SLAVE_ADDR  = 8'h34,
   parameter logic [6:0] VOL_DEFAULT = 7'd121,
   parameter logic [6:0] VOL_MIN     = 7'd48,
   parameter logic [6:0] VOL_MAX     = 7'd127,
   parameter logic [6:0] VOL_STEP    = 7'd3,
   parameter logic       ZC_EN       = 1'b1,
   parameter logic [1:0] MAX_RETRY   = 2'd3
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iTICK,
   input  logic        iCFG_DONE,
   input  logic        iVOL_UP,
   input  logic        iVOL_DN,
   input  logic        iMUTE,
   output logic [23:0] oI2C_DATA,
   output logic        oI2C_GO,
   input  logic        iI2C_END,
   input  logic        iI2C_ACK,
   output logic [6:0]  oVOL,
   output logic        oMUTED,
   output logic        oBUSY,
   output logic        oERR
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_L,
      S_WAIT_L,
      S_GAP_L,
      S_SEND_R,
      S_WAIT_R,
      S_GAP_R
   } state_t;

   state_t      r_state;
   logic [6:0]  r_vol;
   logic        r_muted;
   logic        r_pending;
   logic [6:0]  r_snapVol;
   logic        r_snapMute;
   logic        r_redo;
   logic [1:0]  r_retry;
   logic [23:0] r_data;
   logic        r_go;
   logic        r_busy;
   logic        r_err;

   logic        w_upOnly;
   logic        w_dnOnly;
   logic [7:0]  w_sum;
   logic [7:0]  w_diff;
   logic [7:0]  w_floorLim;
   logic [6:0]  w_upVol;
   logic [6:0]  w_dnVol;
   logic [6:0]  w_nextVol;
   logic        w_change;
   logic [6:0]  w_wval;
   logic [7:0]  w_dataByte;

   // Saturating step arithmetic is done one bit wider so neither end can wrap
   assign w_upOnly   = iVOL_UP & ~iVOL_DN;
   assign w_dnOnly   = iVOL_DN & ~iVOL_UP;
   assign w_sum      = {1'b0, r_vol} + {1'b0, VOL_STEP};
   assign w_diff     = {1'b0, r_vol} - {1'b0, VOL_STEP};
   assign w_floorLim = {1'b0, VOL_MIN} + {1'b0, VOL_STEP};
   assign w_upVol    = (w_sum > {1'b0, VOL_MAX}) ? VOL_MAX : w_sum[6:0];
   assign w_dnVol    = ({1'b0, r_vol} < w_floorLim) ? VOL_MIN : w_diff[6:0];
   assign w_nextVol  = w_upOnly ? w_upVol : (w_dnOnly ? w_dnVol : r_vol);
   assign w_change   = (w_nextVol != r_vol) | iMUTE;

   // The word on the bus always comes from the snapshot, never the live setting
   assign w_wval     = r_snapMute ? 7'd0 : r_snapVol;
   assign w_dataByte = {ZC_EN, w_wval};

   // Live volume/mute follow the request pulses every clock, independent of the tick
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_vol   <= VOL_DEFAULT;
         r_muted <= 1'b0;
      end else begin
         r_vol   <= w_nextVol;
         r_muted <= r_muted ^ iMUTE;
      end
   end

   // Tick-paced write sequencer; a fresh change always wins over the start-of-sequence clear of pending
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_state    <= S_IDLE;
         r_pending  <= 1'b0;
         r_snapVol  <= VOL_DEFAULT;
         r_snapMute <= 1'b0;
         r_redo     <= 1'b0;
         r_retry    <= 2'd0;
         r_data     <= 24'd0;
         r_go       <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (iTICK) begin
            case (r_state)
               S_IDLE: begin
                  if (iCFG_DONE && r_pending) begin
                     r_snapVol  <= r_vol;
                     r_snapMute <= r_muted;
                     r_pending  <= 1'b0;
                     r_busy     <= 1'b1;
                     r_state    <= S_SEND_L;
                  end
               end
               S_SEND_L: begin
                  r_data  <= {SLAVE_ADDR, 8'h04, w_dataByte};
                  r_go    <= 1'b1;
                  r_state <= S_WAIT_L;
               end
               S_SEND_R: begin
                  r_data  <= {SLAVE_ADDR, 8'h06, w_dataByte};
                  r_go    <= 1'b1;
                  r_state <= S_WAIT_R;
               end
               S_WAIT_L, S_WAIT_R: begin
                  if (iI2C_END) begin
                     r_go <= 1'b0;
                     if (!iI2C_ACK) begin
                        r_retry <= 2'd0;
                        r_state <= (r_state == S_WAIT_L) ? S_GAP_L : S_GAP_R;
                     end else if (r_retry < MAX_RETRY) begin
                        r_retry <= r_retry + 2'd1;
                        r_redo  <= 1'b1;
                        r_state <= (r_state == S_WAIT_L) ? S_GAP_L : S_GAP_R;
                     end else begin
                        r_err   <= 1'b1;
                        r_retry <= 2'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                     end
                  end
               end
               S_GAP_L: begin
                  r_redo  <= 1'b0;
                  r_state <= r_redo ? S_SEND_L : S_SEND_R;
               end
               S_GAP_R: begin
                  r_redo <= 1'b0;
                  if (r_redo) begin
                     r_state <= S_SEND_R;
                  end else begin
                     r_err   <= 1'b0;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
         if (w_change) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign oI2C_DATA = r_data;
   assign oI2C_GO   = r_go;
   assign oVOL      = r_vol;
   assign oMUTED    = r_muted;
   assign oBUSY     = r_busy;
   assign oERR      = r_err;

endmodule

// File: tb/tb_codec_vol_scheduler.sv
// tb_codec_vol_scheduler: drives volume/mute pulses against a small behavioural
// model of the volume rules and an emulated I2C controller that logs every word.
module tb_codec_vol_scheduler;

   logic        iCLK = 1'b0;
   logic        iRST_N = 1'b0;
   logic        iTICK = 1'b0;
   logic        iCFG_DONE = 1'b0;
   logic        iVOL_UP = 1'b0;
   logic        iVOL_DN = 1'b0;
   logic        iMUTE = 1'b0;
   logic        iI2C_END = 1'b0;
   logic        iI2C_ACK = 1'b0;
   logic [23:0] oI2C_DATA;
   logic        oI2C_GO;
   logic [6:0]  oVOL;
   logic        oMUTED;
   logic        oBUSY;
   logic        oERR;

   int          total = 0;
   int          bad = 0;
   int          mVol = 121;
   bit          mMute = 1'b0;
   logic [23:0] xferLog[$];
   int          nackBudget = 0;
   int          tickCnt = 0;
   bit          rActive = 1'b0;
   int          waitCnt = 0;

   codec_vol_scheduler dut (
      .iCLK      (iCLK),
      .iRST_N    (iRST_N),
      .iTICK     (iTICK),
      .iCFG_DONE (iCFG_DONE),
      .iVOL_UP   (iVOL_UP),
      .iVOL_DN   (iVOL_DN),
      .iMUTE     (iMUTE),
      .oI2C_DATA (oI2C_DATA),
      .oI2C_GO   (oI2C_GO),
      .iI2C_END  (iI2C_END),
      .iI2C_ACK  (iI2C_ACK),
      .oVOL      (oVOL),
      .oMUTED    (oMUTED),
      .oBUSY     (oBUSY),
      .oERR      (oERR)
   );

   // 50 MHz system clock
   always #10 iCLK = ~iCLK;

   // Tick strobe every 4th clock plus an emulated I2C controller that logs each GO word
   always @(negedge iCLK) begin
      tickCnt = (tickCnt + 1) % 4;
      iTICK = (tickCnt == 0);
      if (!iRST_N) begin
         rActive  = 1'b0;
         iI2C_END = 1'b0;
         iI2C_ACK = 1'b0;
      end else if (!rActive && oI2C_GO && !iI2C_END) begin
         rActive = 1'b1;
         waitCnt = 3 + int'($urandom_range(0, 4));
         xferLog.push_back(oI2C_DATA);
      end else if (rActive && !iI2C_END) begin
         if (waitCnt > 0) begin
            waitCnt--;
         end else begin
            iI2C_END = 1'b1;
            if (nackBudget > 0) begin
               iI2C_ACK = 1'b1;
               nackBudget--;
            end else begin
               iI2C_ACK = 1'b0;
            end
         end
      end else if (iI2C_END && !oI2C_GO) begin
         iI2C_END = 1'b0;
         iI2C_ACK = 1'b0;
         rActive  = 1'b0;
      end
   end

   // Global watchdog so the run can never hang
   initial begin
      #4ms;
      $display("[TB] FAIL watchdog: simulation still running at 4 ms, required finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected bus word from the volume rules, independent of any DUT state
   function automatic logic [31:0] expWord(input logic [7:0] regAddr, input int vol, input bit mute);
      logic [6:0] v;
      v = mute ? 7'd0 : 7'(vol);
      return {8'h00, 8'h34, regAddr, 1'b1, v};
   endfunction

   // One request pulse, with the reference model updated by the plain rules
   task automatic applyStimulus(input bit up, input bit dn, input bit mute);
      @(negedge iCLK);
      iVOL_UP = up;
      iVOL_DN = dn;
      iMUTE   = mute;
      if (up && !dn) mVol = (mVol + 3 > 127) ? 127 : mVol + 3;
      else if (dn && !up) mVol = (mVol - 3 < 48) ? 48 : mVol - 3;
      if (mute) mMute = !mMute;
      @(negedge iCLK);
      iVOL_UP = 1'b0;
      iVOL_DN = 1'b0;
      iMUTE   = 1'b0;
   endtask

   // Wait until the scheduler has been idle long enough that any pending work would have started
   task automatic waitQuiet();
      int quiet = 0;
      int n = 0;
      while (quiet < 16 && n < 6000) begin
         @(negedge iCLK);
         n++;
         if (!oBUSY && !oI2C_GO) quiet++;
         else quiet = 0;
      end
      checkOutput("settle", 32'(quiet >= 16), 32'd1);
   endtask

   task automatic waitLog(input int target);
      int n = 0;
      while (xferLog.size() < target && n < 3000) begin
         @(negedge iCLK);
         n++;
      end
      checkOutput("log_wait", 32'(xferLog.size() >= target), 32'd1);
   endtask

   initial begin
      int base;
      int ticks;
      bit t;
      bit up, dn, mu;
      int r;

      $display("[TB] start");
      iCFG_DONE = 1'b1;
      #15;
      checkOutput("rst_vol", 32'(oVOL), 32'd121);
      checkOutput("rst_muted", 32'(oMUTED), 32'd0);
      checkOutput("rst_go", 32'(oI2C_GO), 32'd0);
      checkOutput("rst_data", 32'(oI2C_DATA), 32'd0);
      checkOutput("rst_busy", 32'(oBUSY), 32'd0);
      checkOutput("rst_err", 32'(oERR), 32'd0);
      @(negedge iCLK);
      iRST_N = 1'b1;
      repeat (4) @(negedge iCLK);

      // single up: latency to GO, then left/right words
      base = xferLog.size();
      @(negedge iCLK);
      iVOL_UP = 1'b1;
      mVol = mVol + 3;
      @(posedge iCLK);
      #1 iVOL_UP = 1'b0;
      ticks = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge iCLK);
         t = iTICK;
         #1;
         if (t) ticks++;
         if (oI2C_GO) break;
      end
      checkOutput("go_latency_ticks", 32'(ticks), 32'd2);
      waitQuiet();
      checkOutput("up_vol", 32'(oVOL), 32'd124);
      checkOutput("up_count", 32'(xferLog.size() - base), 32'd2);
      checkOutput("up_left", 32'(xferLog[base]), 32'h3404FC);
      checkOutput("up_right", 32'(xferLog[base+1]), 32'h3406FC);
      checkOutput("up_busy", 32'(oBUSY), 32'd0);
      checkOutput("up_err", 32'(oERR), 32'd0);

      // saturation at the ceiling
      repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);
      waitQuiet();
      checkOutput("sat_vol", 32'(oVOL), 32'(mVol));
      checkOutput("sat_vol_127", 32'(oVOL), 32'd127);
      checkOutput("sat_left", 32'(xferLog[xferLog.size()-2]), expWord(8'h04, mVol, mMute));
      checkOutput("sat_right", 32'(xferLog[xferLog.size()-1]), expWord(8'h06, mVol, mMute));
      base = xferLog.size();
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
      waitQuiet();
      checkOutput("sat_noxfer", 32'(xferLog.size() - base), 32'd0);

      // walk down to 100, then mute toggles
      repeat (9) applyStimulus(1'b0, 1'b1, 1'b0);
      waitQuiet();
      checkOutput("dn_vol", 32'(oVOL), 32'd100);
      base = xferLog.size();
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitQuiet();
      checkOutput("mute_count", 32'(xferLog.size() - base), 32'd2);
      checkOutput("mute_left", 32'(xferLog[base]), 32'h340480);
      checkOutput("mute_right", 32'(xferLog[base+1]), 32'h340680);
      checkOutput("mute_vol", 32'(oVOL), 32'd100);
      checkOutput("mute_flag", 32'(oMUTED), 32'd1);
      base = xferLog.size();
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitQuiet();
      checkOutput("unmute_left", 32'(xferLog[base]), 32'h3404E4);
      checkOutput("unmute_flag", 32'(oMUTED), 32'd0);

      // two NACKs on the left, recovered by retry
      nackBudget = 2;
      base = xferLog.size();
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitQuiet();
      checkOutput("retry_count", 32'(xferLog.size() - base), 32'd4);
      for (int i = 0; i < 3; i++)
         checkOutput("retry_left", 32'(xferLog[base+i]), expWord(8'h04, mVol, mMute));
      checkOutput("retry_right", 32'(xferLog[base+3]), expWord(8'h06, mVol, mMute));
      checkOutput("retry_err", 32'(oERR), 32'd0);

      // NACK on every left attempt: abort, no right write
      nackBudget = 4;
      base = xferLog.size();
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitQuiet();
      checkOutput("abort_count", 32'(xferLog.size() - base), 32'd4);
      for (int i = 0; i < 4; i++)
         checkOutput("abort_left", 32'(xferLog[base+i]), expWord(8'h04, mVol, mMute));
      checkOutput("abort_err", 32'(oERR), 32'd1);
      checkOutput("abort_busy", 32'(oBUSY), 32'd0);
      nackBudget = 0;

      // requests during a sequence coalesce into one follow-up sequence
      base = xferLog.size();
      applyStimulus(1'b0, 1'b1, 1'b0);
      r = mVol;
      waitLog(base + 1);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
      waitQuiet();
      checkOutput("coal_count", 32'(xferLog.size() - base), 32'd4);
      checkOutput("coal_left1", 32'(xferLog[base]), expWord(8'h04, r, mMute));
      checkOutput("coal_right1", 32'(xferLog[base+1]), expWord(8'h06, r, mMute));
      checkOutput("coal_left2", 32'(xferLog[base+2]), expWord(8'h04, mVol, mMute));
      checkOutput("coal_right2", 32'(xferLog[base+3]), expWord(8'h06, mVol, mMute));
      checkOutput("coal_err", 32'(oERR), 32'd0);

      // simultaneous up and down do nothing
      base = xferLog.size();
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitQuiet();
      checkOutput("updn_vol", 32'(oVOL), 32'(mVol));
      checkOutput("updn_count", 32'(xferLog.size() - base), 32'd0);

      // no start until configuration is done
      iCFG_DONE = 1'b0;
      base = xferLog.size();
      applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (60) @(negedge iCLK);
      checkOutput("cfg_hold_count", 32'(xferLog.size() - base), 32'd0);
      checkOutput("cfg_hold_vol", 32'(oVOL), 32'(mVol));
      checkOutput("cfg_hold_busy", 32'(oBUSY), 32'd0);
      iCFG_DONE = 1'b1;
      waitQuiet();
      checkOutput("cfg_count", 32'(xferLog.size() - base), 32'd2);
      checkOutput("cfg_right", 32'(xferLog[base+1]), expWord(8'h06, mVol, mMute));

      // reset while the right word is in flight
      base = xferLog.size();
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitLog(base + 2);
      @(negedge iCLK);
      #2 iRST_N = 1'b0;
      #1;
      checkOutput("rstmid_go", 32'(oI2C_GO), 32'd0);
      checkOutput("rstmid_busy", 32'(oBUSY), 32'd0);
      checkOutput("rstmid_data", 32'(oI2C_DATA), 32'd0);
      checkOutput("rstmid_vol", 32'(oVOL), 32'd121);
      mVol = 121;
      mMute = 1'b0;
      @(negedge iCLK);
      #2 iRST_N = 1'b1;
      repeat (60) @(negedge iCLK);
      checkOutput("rstmid_noxfer", 32'(xferLog.size() - base), 32'd2);
      checkOutput("rstmid_idle", 32'(oBUSY), 32'd0);

      // random pulses checked against the model, then eventual consistency of the bus
      base = xferLog.size();
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 200; i++) begin
         r  = int'($urandom_range(0, 11));
         up = (r == 1) || (r == 4) || (r == 6);
         dn = (r == 2) || (r == 4) || (r == 7);
         mu = (r == 3);
         applyStimulus(up, dn, mu);
      end
      waitQuiet();
      checkOutput("rnd_vol", 32'(oVOL), 32'(mVol));
      checkOutput("rnd_muted", 32'(oMUTED), 32'(mMute));
      checkOutput("rnd_err", 32'(oERR), 32'd0);
      checkOutput("rnd_even", 32'((xferLog.size() - base) % 2), 32'd0);
      checkOutput("rnd_last_left", 32'(xferLog[xferLog.size()-2]), expWord(8'h04, mVol, mMute));
      checkOutput("rnd_last_right", 32'(xferLog[xferLog.size()-1]), expWord(8'h06, mVol, mMute));
      for (int i = base; i + 1 < xferLog.size(); i += 2) begin
         checkOutput("rnd_pair_l", 32'(xferLog[i][23:8]), 32'h3404);
         checkOutput("rnd_pair_r", 32'(xferLog[i+1][23:8]), 32'h3406);
         checkOutput("rnd_pair_data", 32'(xferLog[i+1][7:0]), 32'(xferLog[i][7:0]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
